// File: rtl/deit_pkg.sv
// Shared constants and FSM state type for the input skew feeder datapath.
package deit_pkg;

   localparam int unsigned LANES    = 12;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned VEC_W    = LANES * DATA_W;
   localparam int unsigned LEN_W    = 10;
   localparam int unsigned READ_LAT = 2;

   typedef enum logic [2:0] {
      IDLE,
      SWAP,
      STREAM,
      DRAIN,
      DONE
   } feed_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register with async active-low reset; one per skewed lane.
module skew_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/input_skew_feeder.sv
// Drives ping-pong buffer read/swap for one tile and feeds the array with a
// diagonal wavefront: lane i delayed by i cycles.
module input_skew_feeder
   import deit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_tile_len,
   input  logic              i_bank_ready,
   output logic              o_bank_swap,
   output logic              o_rd_en,
   input  logic [VEC_W-1:0]  i_rd_vec,
   output logic [VEC_W-1:0]  o_array_data,
   output logic [LANES-1:0]  o_array_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned DRAIN_CYC = READ_LAT + LANES - 1;
   localparam int unsigned DRN_W     = $clog2(DRAIN_CYC);
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

   feed_state_t         state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [DRN_W-1:0]    drn_cnt_q, drn_cnt_d;
   logic [READ_LAT-1:0] rd_pipe_q;
   logic                rd_tap;
   logic [VEC_W-1:0]    cap_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         rd_cnt_q  <= '0;
         drn_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         rd_cnt_q  <= rd_cnt_d;
         drn_cnt_q <= drn_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      rd_cnt_d    = rd_cnt_q;
      drn_cnt_d   = drn_cnt_q;
      o_bank_swap = 1'b0;
      o_rd_en     = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // bank_ready is only looked at here; later drops are irrelevant
            if (i_start && i_bank_ready && (i_tile_len != '0)) begin
               len_d   = i_tile_len;
               state_d = SWAP;
            end
         end
         SWAP: begin
            o_bank_swap = 1'b1;
            o_busy      = 1'b1;
            rd_cnt_d    = '0;
            state_d     = STREAM;
         end
         STREAM: begin
            o_rd_en = 1'b1;
            o_busy  = 1'b1;
            if (rd_cnt_q == len_q - LEN_W'(1)) begin
               rd_cnt_d  = '0;
               drn_cnt_d = '0;
               state_d   = DRAIN;
            end else begin
               rd_cnt_d = rd_cnt_q + LEN_W'(1);
            end
         end
         DRAIN: begin
            o_busy = 1'b1;
            if (drn_cnt_q == DRAIN_LAST) begin
               drn_cnt_d = '0;
               state_d   = DONE;
            end else begin
               drn_cnt_d = drn_cnt_q + DRN_W'(1);
            end
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe_q <= '0;
      end else begin
         rd_pipe_q[0] <= o_rd_en;
         for (int unsigned k = 1; k < READ_LAT; k++) begin
            rd_pipe_q[k] <= rd_pipe_q[k-1];
         end
      end
   end

   assign rd_tap   = rd_pipe_q[READ_LAT-1];
   assign cap_data = rd_tap ? i_rd_vec : '0;

   // Lane 0 has no delay, so it bypasses the delay line instead of a 0-deep instance
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      if (i == 0) begin : g_direct
         assign o_array_valid[0]         = rd_tap;
         assign o_array_data[0 +: DATA_W] = cap_data[0 +: DATA_W];
      end else begin : g_skew
         logic [DATA_W:0] lane_out;
         skew_delay_line #(
            .DEPTH (i),
            .W     (DATA_W + 1)
         ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   ({rd_tap, cap_data[i*DATA_W +: DATA_W]}),
            .q_o   (lane_out)
         );
         assign o_array_valid[i]               = lane_out[DATA_W];
         assign o_array_data[i*DATA_W +: DATA_W] = lane_out[DATA_W-1:0];
      end
   end

endmodule
